dac_stream_ctrl: RTL and testbench

- Sample-rate controller that sits in front of dac_nano and drives its 16-bit DACin bus.
- Buffers incoming samples from a valid/ready producer in a small FIFO.
- Presents one sample to the modulator every rate_div+1 clocks.
- Handles priming, underrun, and a click-free ramp to midscale (16'h8000, excess-2^15 zero) on mute or disable.

---
 rtl/dac_stream_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dac_stream_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: sample-rate front end for dac_nano.
// Buffers producer samples in a small FIFO, releases one sample every
// rate_div+1 clocks, and ramps the output to midscale on mute/disable so
// the analog output never steps.
module dac_stream_ctrl #(
  parameter int DW        = 16,
  parameter int DEPTH     = 8,
  parameter int PRIME     = 4,
  parameter int RAMP_STEP = 256,
  parameter int DIV_W     = 16
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     enable,
  input  logic                     mute,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DW-1:0]            DACin,
  output logic                     tick,
  output logic                     underrun,
  output logic [7:0]               underrun_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic [2:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Midscale in excess-2^(DW-1) code is the analog zero.
  localparam logic [DW-1:0] MID       = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW:0]   MID_X     = {1'b0, MID};
  localparam logic [DW:0]   STEP      = (DW+1)'(RAMP_STEP);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_RAMP  = 3'd3,
    S_MUTED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dac_q, dac_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [7:0]       ucnt_q, ucnt_d;
  logic [DW-1:0]    mem_q [DEPTH];

  logic             counting;
  logic             tick_w;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             underrun_w;
  logic [DW-1:0]    head;
  logic [DW:0]      ramp_dn;
  logic [DW:0]      ramp_up;
  logic [DW-1:0]    ramp_val;

  // Handshake and sample-rate strobes, all derived from registered state.
  always_comb begin
    counting   = (state_q == S_RUN) || (state_q == S_RAMP) || (state_q == S_MUTED);
    // >= so that shrinking rate_div mid-count ticks at once instead of
    // wrapping the whole counter.
    tick_w     = counting && (cnt_q >= rate_div);
    empty      = (level_q == '0);
    full       = (level_q == FULL_LVL);
    s_ready    = !full && (state_q != S_IDLE);
    push       = s_valid && s_ready;
    // Every tick drains a sample when one exists, in all counting states,
    // so the producer sees a steady rate even while muted or ramping.
    pop        = tick_w && !empty;
    underrun_w = tick_w && empty && (state_q == S_RUN);
    head       = mem_q[rd_ptr_q];
  end

  // Next ramp code: one extra bit keeps the step from wrapping past 0 or
  // the top code, then the result is clamped at midscale.
  always_comb begin
    ramp_dn  = {1'b0, dac_q} - STEP;
    ramp_up  = {1'b0, dac_q} + STEP;
    ramp_val = MID;
    if (dac_q > MID) begin
      if (ramp_dn > MID_X) ramp_val = ramp_dn[DW-1:0];
    end else begin
      if (ramp_up < MID_X) ramp_val = ramp_up[DW-1:0];
    end
  end

  // Divider: free-runs only while the output is live.
  always_comb begin
    cnt_d = '0;
    if (counting) begin
      if (tick_w) cnt_d = '0;
      else        cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // FIFO pointers and occupancy; IDLE flushes everything each cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
    if (state_q == S_IDLE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Control FSM: state transitions, output code and underrun count.
  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    ucnt_d  = ucnt_q;
    unique case (state_q)
      S_IDLE: begin
        dac_d = MID;
        if (enable) begin
          state_d = S_PRIME;
          ucnt_d  = '0;
        end
      end
      S_PRIME: begin
        if (!enable)                     state_d = S_IDLE;
        else if (level_q >= PRIME_LVL)   state_d = mute ? S_MUTED : S_RUN;
      end
      S_RUN: begin
        if (pop) dac_d = head;
        if (underrun_w && (ucnt_q != 8'hFF)) ucnt_d = ucnt_q + 8'd1;
        if (!enable || mute) state_d = S_RAMP;
      end
      S_RAMP: begin
        if (tick_w) dac_d = ramp_val;
        // Ramp always completes before leaving, even if mute drops mid-way.
        if (dac_q == MID) begin
          if (!enable)   state_d = S_IDLE;
          else if (mute) state_d = S_MUTED;
          else           state_d = S_RUN;
        end
      end
      S_MUTED: begin
        dac_d = MID;
        if (!enable)   state_d = S_IDLE;
        else if (!mute) state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
        dac_d   = MID;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      dac_q    <= MID;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ucnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      dac_q    <= dac_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ucnt_q   <= ucnt_d;
    end
  end

  // Sample storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  assign DACin        = dac_q;
  assign tick         = tick_w;
  assign underrun     = underrun_w;
  assign underrun_cnt = ucnt_q;
  assign level        = level_q;
  assign state        = state_q;

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Directed bench for dac_stream_ctrl: priming, rate/order, full FIFO,
// underrun saturation, mute ramp down, disable ramp up, reset mid-run.
module tb_dac_stream_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        enable;
  logic        mute;
  logic [15:0] rate_div;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] DACin;
  logic        tick;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic [3:0]  level;
  logic [2:0]  state;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int prod_left = 0;
  logic [15:0] prod_inc = 16'h0;
  logic [15:0] exp_seq [17];

  dac_stream_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .mute(mute),
    .rate_div(rate_div), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .DACin(DACin), .tick(tick), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .level(level), .state(state)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock; the producer advances its data after each accepted push.
  task automatic clk1();
    logic pushed;
    pushed = s_valid && s_ready;
    @(posedge Clk); #1;
    if (pushed) begin
      prod_left = prod_left - 1;
      if (prod_left == 0) s_valid = 1'b0;
      else s_data = s_data + prod_inc;
    end
  endtask

  initial begin
    Reset_n = 1'b0; enable = 1'b0; mute = 1'b0; rate_div = 16'd9;
    s_data = 16'h0; s_valid = 1'b0;

    // ---- reset ----
    repeat (3) clk1();
    chk("rst_state", state, 0);
    chk("rst_dac", DACin, 16'h8000);
    chk("rst_level", level, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_tick", tick, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ucnt", underrun_cnt, 0);

    // ---- prime ----
    Reset_n = 1'b1; enable = 1'b1;
    clk1();
    chk("prime_state", state, 1);
    chk("prime_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 16'hA000; prod_inc = 16'h0100; prod_left = 4;
    repeat (3) clk1();
    chk("prime3_level", level, 3);
    chk("prime3_state", state, 1);
    chk("prime3_tick", tick, 0);
    clk1();
    chk("prime4_level", level, 4);
    clk1();
    chk("run_state", state, 2);
    for (int i = 0; i < 9; i++) begin
      chk("first_tick_early", tick, 0);
      clk1();
    end
    chk("first_tick", tick, 1);
    chk("first_tick_dac_old", DACin, 16'h8000);
    clk1();
    chk("first_sample", DACin, 16'hA000);
    chk("first_level", level, 3);

    // ---- rate 4 clocks, ordering, full FIFO ----
    exp_seq[0] = 16'hA000; exp_seq[1] = 16'hA100;
    exp_seq[2] = 16'hA200; exp_seq[3] = 16'hA300;
    for (int k = 4; k <= 16; k++) exp_seq[k] = 16'((k - 3) * 16'h1000);
    rate_div = 16'd3;
    s_data = 16'h1000; prod_inc = 16'h1000; prod_left = 13; s_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      clk1();
      if (k == 9) begin
        chk("full_level", level, 8);
        chk("full_ready", s_ready, 0);
      end
      clk1(); clk1();
      chk("hold_between_ticks", DACin, exp_seq[k-1]);
      clk1();
      chk("stream_order", DACin, exp_seq[k]);
      chk("stream_no_underrun", underrun_cnt, 0);
    end
    chk("drained_level", level, 0);

    // ---- underrun ----
    clk1(); clk1(); clk1();
    chk("ur_tick", tick, 1);
    chk("ur_pulse", underrun, 1);
    clk1();
    chk("ur_hold_dac", DACin, 16'hD000);
    chk("ur_cnt1", underrun_cnt, 1);
    chk("ur_pulse_off", underrun, 0);
    rate_div = 16'd0;
    repeat (10) clk1();
    chk("ur_cnt11", underrun_cnt, 11);
    chk("ur_every_cycle", underrun, 1);
    repeat (260) clk1();
    chk("ur_sat", underrun_cnt, 255);
    chk("ur_sat_hold_dac", DACin, 16'hD000);

    // ---- mute ramp down from F000 ----
    s_data = 16'hF000; prod_inc = 16'h0; prod_left = 1; s_valid = 1'b1;
    clk1(); clk1();
    chk("ramp_start_dac", DACin, 16'hF000);
    chk("ramp_start_level", level, 0);
    rate_div = 16'd3; mute = 1'b1;
    for (int m = 1; m <= 112; m++) begin
      s_data = 16'h1234; prod_left = 1; s_valid = 1'b1;
      clk1();
      if (m == 1) chk("ramp_state", state, 3);
      clk1(); clk1(); clk1();
      chk("ramp_down_dac", DACin, 32'(16'hF000 - m * 16'h0100));
      chk("ramp_drain_level", level, 0);
    end
    clk1();
    chk("muted_state", state, 4);
    chk("muted_dac", DACin, 16'h8000);

    // ---- unmute, play 0100, disable: ramp up ----
    mute = 1'b0; s_data = 16'h0100; prod_left = 1; s_valid = 1'b1;
    clk1();
    chk("unmute_state", state, 2);
    clk1(); clk1();
    chk("low_sample", DACin, 16'h0100);
    enable = 1'b0;
    for (int m = 1; m <= 127; m++) begin
      clk1();
      if (m == 1) chk("ramp_up_state", state, 3);
      clk1(); clk1(); clk1();
      chk("ramp_up_dac", DACin, 32'(16'h0100 + m * 16'h0100));
    end
    clk1();
    chk("disable_idle", state, 0);
    chk("disable_level", level, 0);
    chk("disable_ready", s_ready, 0);
    chk("disable_dac", DACin, 16'h8000);

    // ---- re-enable, rate_div shrink, reset mid-run ----
    enable = 1'b1; rate_div = 16'd100;
    clk1();
    chk("reprime_state", state, 1);
    chk("reprime_ucnt_clear", underrun_cnt, 0);
    s_data = 16'h5555; prod_inc = 16'h0; prod_left = 5; s_valid = 1'b1;
    repeat (5) clk1();
    chk("rerun_state", state, 2);
    chk("rerun_level", level, 5);
    repeat (3) clk1();
    chk("slow_no_tick", tick, 0);
    rate_div = 16'd1;
    #1;
    chk("shrink_immediate_tick", tick, 1);
    clk1();
    chk("shrink_sample", DACin, 16'h5555);
    chk("shrink_level", level, 4);
    rate_div = 16'd100;
    Reset_n = 1'b0;
    clk1();
    chk("midrst_state", state, 0);
    chk("midrst_level", level, 0);
    chk("midrst_dac", DACin, 16'h8000);
    chk("midrst_ready", s_ready, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_ucnt", underrun_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
